// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory or bus adapter (slave).
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  InstReqValid;
    logic [ADDR_WIDTH-1:0] InstReqAddr;
    logic                  InstReqReady;
    logic                  InstRespValid;
    logic [INST_WIDTH-1:0] InstRespData;

    modport master (
        output InstReqValid,
        output InstReqAddr,
        input  InstReqReady,
        input  InstRespValid,
        input  InstRespData
    );

    modport slave (
        input  InstReqValid,
        input  InstReqAddr,
        output InstReqReady,
        output InstRespValid,
        output InstRespData
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: issues in-order reads from PC, presents instructions to IF/ID, handles redirect and stall.
// Define FETCH_BUF_EN for a 2-entry instruction FIFO with up to two outstanding reads.
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_INIT    = 64'h0000_0000_8000_0000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  JumpFlag,
    input  logic [ADDR_WIDTH-1:0] JumpAddr,
    input  logic [2:0]            HoldFlagFromCtrl,
    inst_fetch_if.master          memBus,
    output logic [ADDR_WIDTH-1:0] InstAddrOut,
    output logic [INST_WIDTH-1:0] InstOut,
    output logic                  InstValidOut
);
    // state | meaning
    // IDLE  | waiting for the output slot to free up (or first cycle after reset)
    // REQ   | read request presented at pc
    // WAIT  | one read accepted, response pending
    // DROP  | redirected while a read was in flight; discard its response

    logic                  holdActive;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] pc;

    assign holdActive = (HoldFlagFromCtrl != 3'b000);
    assign handshake  = memBus.InstReqValid && memBus.InstReqReady;
    assign memBus.InstReqAddr = pc;

`ifndef FETCH_BUF_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic                  slotFree;
    logic [ADDR_WIDTH-1:0] reqAddr;

    // A valid output under hold is the only thing that blocks a new request;
    // the gate is combinational so a hold arriving in REQ withdraws the request.
    assign slotFree            = !InstValidOut || !holdActive;
    assign memBus.InstReqValid = (state == REQ) && slotFree;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (JumpFlag || slotFree) stateNext = REQ;
            REQ:  if (handshake) stateNext = JumpFlag ? DROP : WAIT;
            WAIT: begin
                if (JumpFlag)
                    stateNext = memBus.InstRespValid ? REQ : DROP;
                else if (memBus.InstRespValid)
                    stateNext = holdActive ? IDLE : REQ;
            end
            DROP: if (memBus.InstRespValid) stateNext = REQ;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            pc      <= PC_INIT;
            reqAddr <= PC_INIT;
        end else begin
            state <= stateNext;
            if (JumpFlag) begin
                pc <= JumpAddr;
            end else if (handshake) begin
                pc      <= pc + ADDR_WIDTH'(4);
                reqAddr <= pc;
            end
        end
    end

    // The slot is always empty in WAIT (a request is only accepted while it
    // drains), so a response can be captured regardless of hold.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            InstValidOut <= 1'b0;
            InstOut      <= '0;
            InstAddrOut  <= PC_INIT;
        end else if (JumpFlag) begin
            InstValidOut <= 1'b0;
        end else if (state == WAIT && memBus.InstRespValid) begin
            InstValidOut <= 1'b1;
            InstOut      <= memBus.InstRespData;
            InstAddrOut  <= reqAddr;
        end else if (!holdActive) begin
            InstValidOut <= 1'b0;
        end
    end
`else
    logic                  started;
    logic [1:0]            fifoCnt;
    logic                  fifoWr;
    logic                  fifoRd;
    logic [ADDR_WIDTH-1:0] fifoAddr [2];
    logic [INST_WIDTH-1:0] fifoData [2];
    logic [ADDR_WIDTH-1:0] raMem [2];
    logic                  raWr;
    logic                  raRd;
    logic [1:0]            pendCnt;
    logic [1:0]            pendNext;
    logic [1:0]            dropCnt;
    logic                  respTaken;
    logic                  push;
    logic                  pop;

    // pendCnt counts every read in flight, including ones already marked for
    // discard; dropCnt of those (the oldest) are thrown away on arrival.
    assign memBus.InstReqValid = started && (({1'b0, fifoCnt} + {1'b0, pendCnt}) < 3'd2);
    assign respTaken = memBus.InstRespValid && (pendCnt != 2'd0);
    assign push      = respTaken && (dropCnt == 2'd0) && !JumpFlag;
    assign pop       = (fifoCnt != 2'd0) && !holdActive;
    assign pendNext  = pendCnt + 2'(handshake) - 2'(respTaken);

    assign InstValidOut = (fifoCnt != 2'd0);
    assign InstOut      = fifoData[fifoRd];
    assign InstAddrOut  = fifoAddr[fifoRd];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            started     <= 1'b0;
            pc          <= PC_INIT;
            fifoCnt     <= 2'd0;
            fifoWr      <= 1'b0;
            fifoRd      <= 1'b0;
            fifoAddr[0] <= PC_INIT;
            fifoAddr[1] <= PC_INIT;
            fifoData[0] <= '0;
            fifoData[1] <= '0;
            raMem[0]    <= PC_INIT;
            raMem[1]    <= PC_INIT;
            raWr        <= 1'b0;
            raRd        <= 1'b0;
            pendCnt     <= 2'd0;
            dropCnt     <= 2'd0;
        end else begin
            started <= 1'b1;
            pendCnt <= pendNext;
            if (JumpFlag) begin
                pc      <= JumpAddr;
                fifoCnt <= 2'd0;
                fifoRd  <= fifoWr;
                raWr    <= 1'b0;
                raRd    <= 1'b0;
                dropCnt <= pendNext;
            end else begin
                if (handshake) begin
                    pc          <= pc + ADDR_WIDTH'(4);
                    raMem[raWr] <= pc;
                    raWr        <= ~raWr;
                end
                if (respTaken && dropCnt != 2'd0) begin
                    dropCnt <= dropCnt - 2'd1;
                end
                if (push) begin
                    fifoAddr[fifoWr] <= raMem[raRd];
                    fifoData[fifoWr] <= memBus.InstRespData;
                    fifoWr           <= ~fifoWr;
                    raRd             <= ~raRd;
                end
                if (pop) fifoRd <= ~fifoRd;
                fifoCnt <= fifoCnt + 2'(push) - 2'(pop);
            end
        end
    end
`endif
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_INIT, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_WIDTH, default 64, PC and memory address width.
REQ-003 Parameter INST_WIDTH, default 32, instruction width.
REQ-004 Clk  input  1  single clock, all state on rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 JumpFlag  input  1  redirect request from execute/control.
REQ-007 JumpAddr  input  ADDR_WIDTH  redirect target.
REQ-008 HoldFlagFromCtrl  input  3  stall code; any nonzero value stalls fetch output.
REQ-009 InstReqValid  output  1  memory read request valid.
REQ-010 InstReqAddr  output  ADDR_WIDTH  memory read address.
REQ-011 InstReqReady  input  1  memory accepts request when high with InstReqValid.
REQ-012 InstRespValid  input  1  read data valid, exactly one per accepted request, in order.
REQ-013 InstRespData  input  INST_WIDTH  read data.
REQ-014 InstAddrOut  output  ADDR_WIDTH  address of presented instruction, to IF/ID register.
REQ-015 InstOut  output  INST_WIDTH  presented instruction.
REQ-016 InstValidOut  output  1  InstOut/InstAddrOut valid.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DROP; at most one outstanding request when FETCH_BUF_EN undefined, at most two when defined.
REQ-018 IDLE -> REQ when output slot free and no hold blocking; REQ drives InstReqValid=1, InstReqAddr=pc.
REQ-019 Handshake at REQ with InstReqReady=1: pc <= pc+4 (wrap modulo 2^ADDR_WIDTH), next state WAIT.
REQ-020 WAIT with InstRespValid=1: data and its request address registered to outputs, InstValidOut=1 next cycle; latency response-to-output = 1 cycle.
REQ-021 Back-to-back: WAIT -> REQ on response if slot free, else IDLE.
REQ-022 HoldFlagFromCtrl nonzero: InstOut, InstAddrOut, InstValidOut hold unchanged; no new request issued once the output slot is full.
REQ-023 JumpFlag=1 in cycle t: pc <= JumpAddr; InstValidOut=0 at t+1; buffered instructions flushed.
REQ-024 Jump in WAIT, or in REQ with handshake same cycle: next state DROP; DROP discards InstRespValid data, then -> REQ with new pc.
REQ-025 Jump in REQ without handshake: REQ re-issues with JumpAddr from t+1 (address change before acceptance permitted).
REQ-026 Jump and InstRespValid same cycle: response discarded, next state REQ.
REQ-027 Jump has priority over hold; jump during hold still flushes and redirects.
REQ-028 InstReqValid never high in WAIT or DROP (FETCH_BUF_EN undefined).

Reset
REQ-029 Rst high: state IDLE, pc=PC_INIT, InstValidOut=0, InstOut=0, InstAddrOut=PC_INIT, InstReqValid=0, buffer empty.
REQ-030 Rst asserted mid-transaction: outstanding response after release is ignored (first response after reset accepted only for a request issued after reset).
REQ-031 First InstReqValid in the second cycle after Rst deassertion.

Configuration
REQ-032 Macro FETCH_BUF_EN defined: 2-entry in-order instruction FIFO before outputs; requests continue during hold while (FIFO occupancy + outstanding) < 2; outputs show FIFO head; pop when InstValidOut=1 and hold zero; jump empties FIFO and drops all outstanding responses.
REQ-033 FETCH_BUF_EN undefined: single output register, one outstanding request, behaviour per REQ-017..028.

Verification
REQ-034 Reset release, Ready=1, response 1 cycle after accept, data 32'h00000013 -> InstAddrOut=0x80000000, InstOut=0x00000013, InstValidOut=1; next addr 0x80000004.
REQ-035 Hold=3'b001 for 5 cycles with valid output -> outputs stable 5 cycles, no extra InstReqValid (buffer off), at most 2 accepted (buffer on).
REQ-036 Jump to 0x80000100 while WAIT -> stale response dropped, next InstReqAddr=0x80000100, InstValidOut=0 until its response.
REQ-037 Jump same cycle as InstRespValid -> data never appears on InstOut.
REQ-038 Rst pulsed in WAIT, late response after release -> ignored, fetch restarts at PC_INIT.
REQ-039 pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next InstReqAddr=0x0.
